// File: rtl/multi_cycle_controller_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset controller: FSM state
// encoding, opcode/funct values, aluOp codes and the instruction classes the
// main decoder produces. Helper functions map a class to its EXECUTE behaviour.
package multi_cycle_controller_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_FUNCT = 3'd2;
  localparam logic [2:0] ALU_PASS  = 3'd3;

  typedef enum logic [3:0] {
    CLS_NOP   = 4'd0,
    CLS_RTYPE = 4'd1,
    CLS_JR    = 4'd2,
    CLS_J     = 4'd3,
    CLS_JAL   = 4'd4,
    CLS_BEQ   = 4'd5,
    CLS_BNE   = 4'd6,
    CLS_ADDI  = 4'd7,
    CLS_LW    = 4'd8,
    CLS_SW    = 4'd9,
    CLS_HALT  = 4'd10
  } instr_class_t;

  // Classes whose EXECUTE cycle is also their last (PC commit) cycle.
  function automatic logic is_exec_final(input instr_class_t cls);
    case (cls)
      CLS_NOP, CLS_JR, CLS_J, CLS_JAL, CLS_BEQ, CLS_BNE: return 1'b1;
      default:                                           return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_op_for(input instr_class_t cls);
    case (cls)
      CLS_RTYPE:                  return ALU_FUNCT;
      CLS_ADDI, CLS_LW, CLS_SW:   return ALU_ADD;
      CLS_BEQ, CLS_BNE:           return ALU_SUB;
      default:                    return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_controller_main_decoder.sv
// Main decoder: purely combinational opcode/funct -> instruction class.
// Ports:
//   opcode      in  6  latched instruction opcode
//   funct       in  6  latched instruction funct field
//   instr_class out    decoded class (unknown opcodes decode as CLS_NOP)
//   illegal     out 1  opcode is not part of the supported subset
module multi_cycle_controller_main_decoder
  import multi_cycle_controller_pkg::*;
#(
  parameter logic [5:0] HALT_OPCODE = 6'h3F
) (
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_t instr_class,
  output logic         illegal
);

  always_comb begin
    instr_class = CLS_NOP;
    illegal     = 1'b0;
    // HALT wins even if the parameter collides with a real opcode.
    if (opcode == HALT_OPCODE) begin
      instr_class = CLS_HALT;
    end else begin
      case (opcode)
        OP_RTYPE: instr_class = (funct == FUNCT_JR) ? CLS_JR : CLS_RTYPE;
        OP_J:     instr_class = CLS_J;
        OP_JAL:   instr_class = CLS_JAL;
        OP_BEQ:   instr_class = CLS_BEQ;
        OP_BNE:   instr_class = CLS_BNE;
        OP_ADDI:  instr_class = CLS_ADDI;
        OP_LW:    instr_class = CLS_LW;
        OP_SW:    instr_class = CLS_SW;
        default: begin
          instr_class = CLS_NOP;
          illegal     = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle control FSM for the MIPS-subset core.
// Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, drives PC-handler selects
// with a one-cycle pcWrite per retired instruction, counts retirements.
// Ports:
//   clock, resetN        clock (rising edge), async active-low reset
//   instrIn[31:0]        instruction word, sampled in FETCH when memReady=1
//   zero                 ALU zero flag (consumed by the PC handler, not here)
//   memReady             memory access completes this cycle
//   pcWrite/irWrite/memRead/memWrite/regWrite   datapath strobes
//   aluOp[2:0]           0 add, 1 sub, 2 funct-decoded, 3 pass
//   branchEqual/branchNotEqual/jSignal/jrSignal/jalSignal  PC selects
//   illegal              sticky unknown-opcode flag
//   halted               FSM parked in HALT
//   instrCount           retired-instruction counter (wraps)
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
#(
  parameter int         COUNT_WIDTH = 32,
  parameter logic [5:0] HALT_OPCODE = 6'h3F
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic [31:0]            instrIn,
  input  logic                   zero,
  input  logic                   memReady,
  output logic                   pcWrite,
  output logic                   irWrite,
  output logic                   memRead,
  output logic                   memWrite,
  output logic                   regWrite,
  output logic [2:0]             aluOp,
  output logic                   branchEqual,
  output logic                   branchNotEqual,
  output logic                   jSignal,
  output logic                   jrSignal,
  output logic                   jalSignal,
  output logic                   illegal,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] instrCount
);

  state_t                 state_q, state_d;
  logic [5:0]             opcode_q, opcode_d;
  logic [5:0]             funct_q, funct_d;
  logic                   illegal_q, illegal_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  instr_class_t cls;
  logic         dec_illegal;
  logic         pc_write;

  // zero is resolved by the PC handler; only opcode/funct bits are decoded.
  logic unused_inputs;
  assign unused_inputs = ^{zero, instrIn[25:6]};

  multi_cycle_controller_main_decoder #(
    .HALT_OPCODE (HALT_OPCODE)
  ) u_main_decoder (
    .opcode      (opcode_q),
    .funct       (funct_q),
    .instr_class (cls),
    .illegal     (dec_illegal)
  );

  // Outputs decode from registered state and latched opcode/funct. The only
  // memReady-qualified strobes are irWrite in FETCH and the sw commit in
  // MEMORY, which must land in the cycle the write completes.
  always_comb begin
    pc_write       = 1'b0;
    irWrite        = 1'b0;
    memRead        = 1'b0;
    memWrite       = 1'b0;
    regWrite       = 1'b0;
    aluOp          = ALU_ADD;
    branchEqual    = 1'b0;
    branchNotEqual = 1'b0;
    jSignal        = 1'b0;
    jrSignal       = 1'b0;
    jalSignal      = 1'b0;
    halted         = 1'b0;
    case (state_q)
      ST_FETCH: begin
        memRead = 1'b1;
        irWrite = memReady;
      end
      ST_EXECUTE: begin
        aluOp = alu_op_for(cls);
        if (is_exec_final(cls)) begin
          pc_write       = 1'b1;
          branchEqual    = (cls == CLS_BEQ);
          branchNotEqual = (cls == CLS_BNE);
          jSignal        = (cls == CLS_J);
          jrSignal       = (cls == CLS_JR);
          jalSignal      = (cls == CLS_JAL);
          regWrite       = (cls == CLS_JAL);
        end
      end
      ST_MEMORY: begin
        memRead  = (cls == CLS_LW);
        memWrite = (cls == CLS_SW);
        pc_write = (cls == CLS_SW) && memReady;
      end
      ST_WRITEBACK: begin
        regWrite = 1'b1;
        pc_write = 1'b1;
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign pcWrite    = pc_write;
  assign illegal    = illegal_q;
  assign instrCount = count_q;

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    funct_d   = funct_q;
    illegal_d = illegal_q;
    count_d   = pc_write ? count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1} : count_q;
    case (state_q)
      ST_FETCH: begin
        if (memReady) begin
          opcode_d = instrIn[31:26];
          funct_d  = instrIn[5:0];
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        illegal_d = illegal_q | dec_illegal;
        state_d   = (cls == CLS_HALT) ? ST_HALT : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        case (cls)
          CLS_LW, CLS_SW:      state_d = ST_MEMORY;
          CLS_RTYPE, CLS_ADDI: state_d = ST_WRITEBACK;
          default:             state_d = ST_FETCH;
        endcase
      end
      ST_MEMORY: begin
        if (memReady) state_d = (cls == CLS_LW) ? ST_WRITEBACK : ST_FETCH;
      end
      ST_WRITEBACK: state_d = ST_FETCH;
      ST_HALT:      state_d = ST_HALT;
      default:      state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q   <= ST_FETCH;
      opcode_q  <= 6'd0;
      funct_q   <= 6'd0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      funct_q   <= funct_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
module tb_multi_cycle_controller;

  localparam int CW = 32;

  logic          clock;
  logic          resetN;
  logic [31:0]   instrIn;
  logic          zero;
  logic          memReady;
  logic          pcWrite, irWrite, memRead, memWrite, regWrite;
  logic [2:0]    aluOp;
  logic          branchEqual, branchNotEqual, jSignal, jrSignal, jalSignal;
  logic          illegal, halted;
  logic [CW-1:0] instrCount;

  int            checks = 0;
  int            errors = 0;
  logic [CW-1:0] exp_count = '0;

  // Output vector: {pc, ir, mr, mw, rw, alu[2:0], beq, bne, j, jr, jal, halted}
  localparam logic [13:0] B_PC   = 14'h2000;
  localparam logic [13:0] B_IR   = 14'h1000;
  localparam logic [13:0] B_MR   = 14'h0800;
  localparam logic [13:0] B_MW   = 14'h0400;
  localparam logic [13:0] B_RW   = 14'h0200;
  localparam logic [13:0] A_SUB  = 14'h0040;
  localparam logic [13:0] A_FUN  = 14'h0080;
  localparam logic [13:0] A_PASS = 14'h00C0;
  localparam logic [13:0] S_BEQ  = 14'h0020;
  localparam logic [13:0] S_BNE  = 14'h0010;
  localparam logic [13:0] S_J    = 14'h0008;
  localparam logic [13:0] S_JR   = 14'h0004;
  localparam logic [13:0] S_JAL  = 14'h0002;
  localparam logic [13:0] B_H    = 14'h0001;
  localparam logic [13:0] O_NONE = 14'h0000;
  localparam logic [13:0] O_FET  = B_IR | B_MR;

  multi_cycle_controller #(.COUNT_WIDTH(CW), .HALT_OPCODE(6'h3F)) dut (
    .clock          (clock),
    .resetN         (resetN),
    .instrIn        (instrIn),
    .zero           (zero),
    .memReady       (memReady),
    .pcWrite        (pcWrite),
    .irWrite        (irWrite),
    .memRead        (memRead),
    .memWrite       (memWrite),
    .regWrite       (regWrite),
    .aluOp          (aluOp),
    .branchEqual    (branchEqual),
    .branchNotEqual (branchNotEqual),
    .jSignal        (jSignal),
    .jrSignal       (jrSignal),
    .jalSignal      (jalSignal),
    .illegal        (illegal),
    .halted         (halted),
    .instrCount     (instrCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [13:0] outs();
    return {pcWrite, irWrite, memRead, memWrite, regWrite, aluOp,
            branchEqual, branchNotEqual, jSignal, jrSignal, jalSignal, halted};
  endfunction

  task automatic test_reset();
    resetN = 1'b0; memReady = 1'b0; instrIn = '0; zero = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if (outs() !== B_MR) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", outs(), B_MR);
    end
    checks++;
    if (instrCount !== '0 || illegal !== 1'b0) begin
      errors++; $display("FAIL reset_state: count %0d illegal %b expected 0 0", instrCount, illegal);
    end
    resetN = 1'b1;
    @(posedge clock); #1;
  endtask

  // R-type add then addi, memReady high: 4 cycles each, commit in cycle 4.
  task automatic test_alu_ops();
    logic [31:0] instr [2];
    logic [13:0] ev [2][4];
    instr = '{32'h0043_2020, 32'h2001_0005};
    ev = '{'{O_FET, O_NONE, A_FUN,  B_PC | B_RW},
           '{O_FET, O_NONE, O_NONE, B_PC | B_RW}};
    for (int i = 0; i < 2; i++) begin
      instrIn = instr[i]; memReady = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(negedge clock);
        checks++;
        if (outs() !== ev[i][c]) begin
          errors++; $display("FAIL alu_ops instr %0d cycle %0d: got %h expected %h", i, c + 1, outs(), ev[i][c]);
        end
        @(posedge clock); #1;
      end
      exp_count++;
      checks++;
      if (instrCount !== exp_count) begin
        errors++; $display("FAIL alu_ops_count instr %0d: got %0d expected %0d", i, instrCount, exp_count);
      end
    end
  endtask

  // lw with three stall cycles in MEMORY: commit lands in cycle 8.
  task automatic test_lw_stall();
    logic        mr [8];
    logic [13:0] ev [8];
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    ev = '{O_FET, O_NONE, O_NONE, B_MR, B_MR, B_MR, B_MR, B_PC | B_RW};
    instrIn = 32'h8C22_0004;
    for (int c = 0; c < 8; c++) begin
      memReady = mr[c];
      @(negedge clock);
      checks++;
      if (outs() !== ev[c]) begin
        errors++; $display("FAIL lw_stall cycle %0d: got %h expected %h", c + 1, outs(), ev[c]);
      end
      @(posedge clock); #1;
    end
    exp_count++;
    checks++;
    if (instrCount !== exp_count) begin
      errors++; $display("FAIL lw_stall_count: got %0d expected %0d", instrCount, exp_count);
    end
  endtask

  // sw without stall: write and commit together in cycle 4.
  task automatic test_sw();
    logic [13:0] ev [4];
    ev = '{O_FET, O_NONE, O_NONE, B_MW | B_PC};
    instrIn = 32'hAC22_0008; memReady = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      checks++;
      if (outs() !== ev[c]) begin
        errors++; $display("FAIL sw cycle %0d: got %h expected %h", c + 1, outs(), ev[c]);
      end
      @(posedge clock); #1;
    end
    exp_count++;
    checks++;
    if (instrCount !== exp_count) begin
      errors++; $display("FAIL sw_count: got %0d expected %0d", instrCount, exp_count);
    end
  endtask

  // Three-cycle control flow: beq(z=1), bne(z=1), beq(z=0), jal, jr, j, back to back.
  task automatic test_control_flow();
    logic [31:0] instr [6];
    logic        zv [6];
    logic [13:0] ex [6];
    instr = '{32'h1022_0003, 32'h1422_0003, 32'h1022_0003,
              32'h0C00_0010, 32'h03E0_0008, 32'h0800_0010};
    zv    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    ex    = '{B_PC | A_SUB | S_BEQ, B_PC | A_SUB | S_BNE, B_PC | A_SUB | S_BEQ,
              B_PC | B_RW | A_PASS | S_JAL, B_PC | A_PASS | S_JR, B_PC | A_PASS | S_J};
    for (int i = 0; i < 6; i++) begin
      instrIn = instr[i]; zero = zv[i]; memReady = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clock);
        checks++;
        if (outs() !== ((c == 0) ? O_FET : (c == 1) ? O_NONE : ex[i])) begin
          errors++; $display("FAIL control_flow instr %0d cycle %0d: got %h", i, c + 1, outs());
        end
        @(posedge clock); #1;
      end
      exp_count++;
      checks++;
      if (instrCount !== exp_count) begin
        errors++; $display("FAIL control_flow_count instr %0d: got %0d expected %0d", i, instrCount, exp_count);
      end
    end
    zero = 1'b0;
  endtask

  // Unknown opcode 0x11 retires as a 3-cycle NOP and sets sticky illegal.
  task automatic test_illegal();
    logic [13:0] ev [3];
    ev = '{O_FET, O_NONE, B_PC | A_PASS};
    checks++;
    if (illegal !== 1'b0) begin
      errors++; $display("FAIL illegal_pre: got %b expected 0", illegal);
    end
    instrIn = 32'h4400_0000; memReady = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if (outs() !== ev[c]) begin
        errors++; $display("FAIL illegal_nop cycle %0d: got %h expected %h", c + 1, outs(), ev[c]);
      end
      @(posedge clock); #1;
    end
    exp_count++;
    checks++;
    if (illegal !== 1'b1 || instrCount !== exp_count) begin
      errors++; $display("FAIL illegal_post: illegal %b count %0d expected 1 %0d", illegal, instrCount, exp_count);
    end
  endtask

  // HALT opcode parks the FSM; nothing retires for 20 cycles.
  task automatic test_halt();
    instrIn = 32'hFC00_0000; memReady = 1'b1;
    @(negedge clock);
    checks++;
    if (outs() !== O_FET) begin
      errors++; $display("FAIL halt_fetch: got %h expected %h", outs(), O_FET);
    end
    @(posedge clock); #1;
    @(negedge clock);
    checks++;
    if (outs() !== O_NONE) begin
      errors++; $display("FAIL halt_decode: got %h expected %h", outs(), O_NONE);
    end
    for (int c = 0; c < 20; c++) begin
      @(posedge clock); #1;
      instrIn = 32'h0043_2020;
      @(negedge clock);
      checks++;
      if (outs() !== B_H) begin
        errors++; $display("FAIL halt_parked cycle %0d: got %h expected %h", c, outs(), B_H);
      end
    end
    checks++;
    if (instrCount !== exp_count || illegal !== 1'b1) begin
      errors++; $display("FAIL halt_state: count %0d illegal %b expected %0d 1", instrCount, illegal, exp_count);
    end
  endtask

  // Reset exits HALT; then reset asserted in the middle of a stalled sw.
  task automatic test_reset_mid_sw();
    logic [13:0] ev [3];
    @(posedge clock); #1;
    memReady = 1'b0;
    resetN = 1'b0;
    @(negedge clock);
    checks++;
    if (outs() !== B_MR || instrCount !== '0) begin
      errors++; $display("FAIL halt_exit_reset: got %h count %0d expected %h 0", outs(), instrCount, B_MR);
    end
    resetN = 1'b1;
    exp_count = '0;
    @(posedge clock); #1;
    ev = '{O_FET, O_NONE, B_PC | A_PASS};
    instrIn = 32'h4400_0000; memReady = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      @(posedge clock); #1;
    end
    checks++;
    if (instrCount !== 32'd1 || illegal !== 1'b1) begin
      errors++; $display("FAIL pre_sw_state: count %0d illegal %b expected 1 1", instrCount, illegal);
    end
    instrIn = 32'hAC22_0008;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if (outs() !== ((c == 0) ? O_FET : O_NONE)) begin
        errors++; $display("FAIL sw_lead cycle %0d: got %h", c + 1, outs());
      end
      @(posedge clock); #1;
    end
    memReady = 1'b0;
    @(negedge clock);
    checks++;
    if (outs() !== B_MW) begin
      errors++; $display("FAIL sw_stall: got %h expected %h", outs(), B_MW);
    end
    @(posedge clock); #1;
    #2 resetN = 1'b0;
    #1;
    checks++;
    if (outs() !== B_MR) begin
      errors++; $display("FAIL mid_reset_outputs: got %h expected %h", outs(), B_MR);
    end
    checks++;
    if (instrCount !== '0 || illegal !== 1'b0) begin
      errors++; $display("FAIL mid_reset_state: count %0d illegal %b expected 0 0", instrCount, illegal);
    end
    @(negedge clock);
    resetN = 1'b1;
    @(posedge clock); #1;
    instrIn = 32'h0800_0010; memReady = 1'b1;
    ev = '{O_FET, O_NONE, B_PC | A_PASS | S_J};
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++;
      if (outs() !== ev[c]) begin
        errors++; $display("FAIL post_reset_j cycle %0d: got %h expected %h", c + 1, outs(), ev[c]);
      end
      @(posedge clock); #1;
    end
    checks++;
    if (instrCount !== 32'd1) begin
      errors++; $display("FAIL post_reset_count: got %0d expected 1", instrCount);
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_lw_stall();
    test_sw();
    test_control_flow();
    test_illegal();
    test_halt();
    test_reset_mid_sw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_cycle_controller.md
Name: multi_cycle_controller

Overview:
Multi-cycle control FSM that sequences the program-counter handler, instruction register, ALU, register file and data memory for the MIPS-subset core. It latches the fetched opcode and funct, steps through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, and drives the branch/jump select signals together with a single-cycle pcWrite strobe that commits newPC. Memory accesses use a ready handshake so slow memories stall the FSM.

Parameters:
COUNT_WIDTH, 32, width of retired-instruction counter
HALT_OPCODE, 6'h3F, opcode that parks the FSM in HALT

Ports:
clock  input  1  system clock, rising edge
resetN  input  1  asynchronous active-low reset
instrIn  input  32  instruction word from instruction memory, valid when memReady=1 in FETCH
zero  input  1  ALU zero flag, valid in EXECUTE
memReady  input  1  memory access complete this cycle
pcWrite  output  1  commit newPC to PC register (one cycle per instruction)
irWrite  output  1  load instruction register
memRead  output  1  memory read request
memWrite  output  1  memory write request
regWrite  output  1  register-file write enable
aluOp  output  3  0 add, 1 sub, 2 funct-decoded, 3 pass
branchEqual  output  1  beq select to PC handler
branchNotEqual  output  1  bne select to PC handler
jSignal  output  1  j select
jrSignal  output  1  jr select
jalSignal  output  1  jal select (also requests $31 write)
illegal  output  1  sticky: unknown opcode seen
halted  output  1  FSM in HALT
instrCount  output  COUNT_WIDTH  retired instructions

Behaviour:
- Reset (resetN=0, async, any state incl. mid-access): state=FETCH, latched opcode/funct=0, illegal=0, instrCount=0; all outputs 0 except memRead=1 (FETCH state output).
- Moore outputs decoded from registered state + latched opcode/funct; no combinational path from memReady/zero to any output.
- FETCH: memRead=1. Stays while memReady=0. On memReady=1: irWrite=1 (combinational with memReady allowed only for irWrite), latch instrIn[31:26]/[5:0], -> DECODE.
- DECODE: one cycle. HALT_OPCODE -> HALT. Unknown opcode -> set illegal, treat as NOP: -> RETIRE path (EXECUTE with sequential PC). Else -> EXECUTE.
- EXECUTE: aluOp per class (R-type 2, addi/lw/sw 0, beq/bne 1).
  - beq/bne/j/jal/jr/NOP: final cycle: pcWrite=1, matching select asserted (jal also regWrite=1), -> FETCH.
  - lw/sw -> MEMORY; R-type/addi -> WRITEBACK.
- MEMORY: memRead (lw) or memWrite (sw) held until memReady=1. sw: pcWrite=1 in the memReady cycle, -> FETCH. lw: -> WRITEBACK.
- WRITEBACK: regWrite=1, pcWrite=1, -> FETCH.
- HALT: all strobes 0, halted=1; exits only by reset.
- Opcodes: 0x00 R-type (funct 0x08 = jr), 0x02 j, 0x03 jal, 0x04 beq, 0x05 bne, 0x08 addi, 0x23 lw, 0x2B sw.
- Latency (memReady=1 each access): branch/jump/NOP 3, R-type/addi/sw 4, lw 5 cycles; each memReady=0 cycle adds 1.
- Select signals valid only in the pcWrite cycle; at most one select high; zero=0 with beq still pcWrites (handler yields oldPC+1).
- instrCount += 1 on every pcWrite, wraps modulo 2^COUNT_WIDTH.

Decomposition:
- Shared package: state encoding constants (FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, HALT, 3 bits), opcode/funct constants, aluOp codes.
- Sub-module main_decoder: combinational opcode/funct -> instruction class + illegal; FSM stays in the top.

Test Plan:
- R-type add (0x00, funct 0x20), memReady=1 -> pcWrite only in cycle 4, regWrite cycle 4, aluOp=2 in EXECUTE, instrCount 0->1.
- lw with memReady low 3 cycles in MEMORY -> memRead held, pcWrite at cycle 8, regWrite with it.
- beq zero=1 then bne zero=1 -> each 3 cycles, branchEqual/branchNotEqual high only with pcWrite.
- jal then jr (funct 0x08) -> jalSignal+regWrite in cycle 3; jrSignal in jr's cycle 3; never two selects at once.
- opcode 0x11 -> illegal=1 sticky, NOP retires in 3 cycles; then 0x3F -> halted=1, no further pcWrite for 20 cycles.
- resetN low during MEMORY stall of sw -> immediate state FETCH, memWrite=0, instrCount=0, illegal=0.
